// File: rtl/uart_score_scheduler_pkg.sv
// uart_score_scheduler_pkg: shared types, frame length and byte-mux helper for the score reporter
//   state_t      : scheduler FSM states
//   frame_type_t : TYPE byte values carried in byte 1 of every frame
//   FRAME_LEN    : bytes per frame (HDR, TYPE, P1, P2, CHK)
//   frame_byte() : selects the frame byte for a given index; CHK excludes the header
package uart_score_scheduler_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_ACK, WAIT_DONE} state_t;

   typedef enum logic [7:0] {
      FT_SCORE     = 8'h01,
      FT_GAMEOVER  = 8'h02,
      FT_HEARTBEAT = 8'h03
   } frame_type_t;

   localparam int FRAME_LEN = 5;

   function automatic logic [7:0] frame_byte(
      input logic [2:0] idx,
      input logic [7:0] hdr,
      input logic [7:0] ftype,
      input logic [7:0] p1,
      input logic [7:0] p2
   );
      return (idx == 3'd0) ? hdr   :
             (idx == 3'd1) ? ftype :
             (idx == 3'd2) ? p1    :
             (idx == 3'd3) ? p2    : (ftype ^ p1 ^ p2);
   endfunction

endpackage

// File: rtl/uart_req_arbiter.sv
// uart_req_arbiter: pending report flags, heartbeat timer and fixed-priority grant
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_score_update      : 1-cycle pulse, sets the score flag
//   i_game_over         : 1-cycle pulse, sets the game-over flag
//   i_grant_ack         : frame start; clears the granted flag and restarts the heartbeat timer
//   o_grant_valid       : any flag pending
//   o_grant_type        : highest-priority pending type (game over > score > heartbeat)
module uart_req_arbiter
   import uart_score_scheduler_pkg::*;
#(
   parameter int HEARTBEAT_CYCLES = 100_000_000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_score_update,
   input  logic        i_game_over,
   input  logic        i_grant_ack,
   output logic        o_grant_valid,
   output frame_type_t o_grant_type
);

   localparam int CW = $clog2(HEARTBEAT_CYCLES + 1);

   logic [CW-1:0] r_hb_cnt;
   logic          r_pend_go;
   logic          r_pend_sc;
   logic          r_pend_hb;
   logic          w_hb_wrap;
   logic          w_clr_go;
   logic          w_clr_sc;
   logic          w_clr_hb;

   assign w_hb_wrap     = (r_hb_cnt == CW'(HEARTBEAT_CYCLES - 1));
   assign o_grant_valid = r_pend_go | r_pend_sc | r_pend_hb;
   assign o_grant_type  = r_pend_go ? FT_GAMEOVER : r_pend_sc ? FT_SCORE : FT_HEARTBEAT;
   assign w_clr_go      = i_grant_ack & r_pend_go;
   assign w_clr_sc      = i_grant_ack & ~r_pend_go & r_pend_sc;
   assign w_clr_hb      = i_grant_ack & ~r_pend_go & ~r_pend_sc & r_pend_hb;

   // A request pulse coinciding with its own grant re-arms the flag so it is not lost.
   // A frame start takes precedence over a heartbeat wrap in the same cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pend_go <= 1'b0;
         r_pend_sc <= 1'b0;
         r_pend_hb <= 1'b0;
         r_hb_cnt  <= '0;
      end else begin
         r_pend_go <= (r_pend_go & ~w_clr_go) | i_game_over;
         r_pend_sc <= (r_pend_sc & ~w_clr_sc) | i_score_update;
         r_pend_hb <= (r_pend_hb & ~w_clr_hb) | (w_hb_wrap & ~i_grant_ack);
         r_hb_cnt  <= (i_grant_ack | w_hb_wrap) ? '0 : r_hb_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/uart_score_scheduler.sv
// uart_score_scheduler: builds 5-byte score report frames and sequences them into a byte UART TX
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_score_update        : 1-cycle pulse, a score changed
//   i_game_over           : 1-cycle pulse, match finished
//   i_points_p1/p2        : 4-bit scores, snapshot at frame start
//   i_tx_busy             : UART busy, rises the cycle after o_tx_start
//   o_tx_start            : 1-cycle load strobe to the UART
//   o_tx_data             : byte to send, held until the next load
//   o_frame_active        : frame in progress
//   o_frame_done          : 1-cycle pulse after CHK completes
//   o_frame_err           : 1-cycle pulse when the UART never acknowledged a byte
module uart_score_scheduler
   import uart_score_scheduler_pkg::*;
#(
   parameter int         HEARTBEAT_CYCLES = 100_000_000,
   parameter int         ACK_TIMEOUT      = 16,
   parameter logic [7:0] HDR_BYTE         = 8'hA5
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_score_update,
   input  logic       i_game_over,
   input  logic [3:0] i_points_p1,
   input  logic [3:0] i_points_p2,
   input  logic       i_tx_busy,
   output logic       o_tx_start,
   output logic [7:0] o_tx_data,
   output logic       o_frame_active,
   output logic       o_frame_done,
   output logic       o_frame_err
);

   localparam int TW = $clog2(ACK_TIMEOUT + 1);

   state_t        r_state;
   logic [7:0]    r_type;
   logic [7:0]    r_p1;
   logic [7:0]    r_p2;
   logic [2:0]    r_idx;
   logic [TW-1:0] r_tmo;
   logic          w_grant_valid;
   frame_type_t   w_grant_type;
   logic          w_grant_ack;
   logic [7:0]    w_byte;

   assign w_grant_ack = (r_state == LOAD);
   assign w_byte      = frame_byte(r_idx, HDR_BYTE, r_type, r_p1, r_p2);

   uart_req_arbiter #(
      .HEARTBEAT_CYCLES(HEARTBEAT_CYCLES)
   ) u_arb (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_score_update(i_score_update),
      .i_game_over   (i_game_over),
      .i_grant_ack   (w_grant_ack),
      .o_grant_valid (w_grant_valid),
      .o_grant_type  (w_grant_type)
   );

   // The timeout counter starts with the load strobe, so the abort lands
   // ACK_TIMEOUT cycles after o_tx_start was raised.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state        <= IDLE;
         r_type         <= 8'h00;
         r_p1           <= 8'h00;
         r_p2           <= 8'h00;
         r_idx          <= 3'd0;
         r_tmo          <= '0;
         o_tx_start     <= 1'b0;
         o_tx_data      <= 8'h00;
         o_frame_active <= 1'b0;
         o_frame_done   <= 1'b0;
         o_frame_err    <= 1'b0;
      end else begin
         o_tx_start   <= 1'b0;
         o_frame_done <= 1'b0;
         o_frame_err  <= 1'b0;
         case (r_state)
            IDLE: r_state <= (w_grant_valid && !i_tx_busy) ? LOAD : IDLE;
            LOAD: begin
               r_type         <= w_grant_type;
               r_p1           <= {4'h0, i_points_p1};
               r_p2           <= {4'h0, i_points_p2};
               r_idx          <= 3'd0;
               o_frame_active <= 1'b1;
               r_state        <= START;
            end
            START: begin
               o_tx_data  <= w_byte;
               o_tx_start <= 1'b1;
               r_tmo      <= '0;
               r_state    <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (i_tx_busy) begin
                  r_state <= WAIT_DONE;
               end else if (r_tmo == TW'(ACK_TIMEOUT - 1)) begin
                  o_frame_err    <= 1'b1;
                  o_frame_active <= 1'b0;
                  r_state        <= IDLE;
               end else begin
                  r_tmo <= r_tmo + TW'(1);
               end
            end
            WAIT_DONE: begin
               if (!i_tx_busy) begin
                  if (r_idx == 3'(FRAME_LEN - 1)) begin
                     o_frame_done   <= 1'b1;
                     o_frame_active <= 1'b0;
                     r_state        <= IDLE;
                  end else begin
                     r_idx   <= r_idx + 3'd1;
                     r_state <= START;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
